// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv
//  ALU controller for the multi-cycle datapath. Decodes ALUOp_i/funct_i into
//  the 4-bit ALU select. It also runs an iterative unsigned multiply/divide
//  sequencer (multu/divu) that writes HI/LO. While a sequence runs, stall_o
//  interlocks mfhi/mflo and any new mul/div request.
// Ports
//  clk_i      clock, rising edge
//  rst_i      asynchronous active-low reset
//  valid_i    instruction in decode is valid
//  ALUOp_i    ALU op class from main decoder
//  funct_i    R-type funct field
//  src1_i     rs value (multiplicand / dividend)
//  src2_i     rt value (multiplier / divisor)
//  ALUCtrl_o  ALU select (combinational)
//  stall_o    hold PC/IF/ID this cycle
//  busy_o     sequencer iterating (MUL or DIV)
//  done_o     one-cycle pulse, HI/LO just updated
//  hi_o/lo_o  HI/LO registers
module alu_ctrl_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          HAS_DIV = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [3:0]       ALUCtrl_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     opnd_q;    // multiplicand or divisor
  logic                 is_r, is_mul, is_div, is_mf, accept;
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_next, div_next, step_next;

  // Decode
  always_comb begin
    ALUCtrl_o = 4'b0000;
    case (ALUOp_i)
      3'b010: begin
        case (funct_i)
          6'b100000: ALUCtrl_o = 4'b0010;
          6'b100010: ALUCtrl_o = 4'b0110;
          6'b100100: ALUCtrl_o = 4'b0000;
          6'b100101: ALUCtrl_o = 4'b0001;
          6'b101010: ALUCtrl_o = 4'b0111;
          F_MULTU, F_DIVU, F_MFHI, F_MFLO: ALUCtrl_o = 4'b1111;
          default:   ALUCtrl_o = 4'b0000;
        endcase
      end
      3'b100:  ALUCtrl_o = 4'b1000;
      3'b011:  ALUCtrl_o = 4'b0100;
      3'b001:  ALUCtrl_o = 4'b1010;
      3'b111:  ALUCtrl_o = 4'b0101;
      default: ALUCtrl_o = 4'b0000;
    endcase
  end

  assign is_r   = (ALUOp_i == 3'b010);
  assign is_mul = is_r && (funct_i == F_MULTU);
  assign is_div = HAS_DIV && is_r && (funct_i == F_DIVU);
  assign is_mf  = is_r && ((funct_i == F_MFHI) || (funct_i == F_MFLO));
  assign accept = valid_i && (state_q == S_IDLE) && (is_mul || is_div);

  assign busy_o  = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o  = (state_q == S_DONE);
  // The issuing mul/div is held through its iterations and released in DONE.
  assign stall_o = accept || (valid_i && busy_o && (is_mul || is_div || is_mf));

  // Shift-add multiply step: conditionally add, then shift the 2W register right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step. A borrow out of the W+1 bit subtract means the
  // shifted remainder is below the divisor.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  assign step_next = (state_q == S_DIV) ? div_next : mul_next;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept) state_d = is_mul ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q <= CW'(WIDTH - 1);
            if (is_mul) begin
              acc_q  <= (2*WIDTH)'(src2_i);
              opnd_q <= src1_i;
            end else begin
              acc_q  <= (2*WIDTH)'(src1_i);
              opnd_q <= src2_i;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= step_next;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            {hi_o, lo_o} <= step_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
